// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared types and arithmetic helpers for the binary NN engines
//
// Contents:
//   state_t        conv FSM states (IDLE, RUN)
//   result_w(k)    signed result width for a k*k XNOR-popcount window
//   xnor_popcount  count of matching bits among the low n bits of a and b

package bnn_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Widest operand the popcount helper accepts (K=7 needs 49 bits).
    localparam int POP_MAX = 64;

    function automatic int result_w(input int k);
        return $clog2(k * k + 1) + 1;
    endfunction

    // Bits at positions >= n are ignored so one helper serves every kernel size.
    function automatic int xnor_popcount(input logic [POP_MAX-1:0] a,
                                         input logic [POP_MAX-1:0] b,
                                         input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            if ((i < n) && (a[i] ~^ b[i])) begin
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bnn_conv_mc_window_buf.sv
// rtl/bnn_conv_mc_window_buf.sv - K-row line buffers, KxK window and raster counters
//
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   clear       zero the row/col counters (frame start)
//   en          accepted pixel beat; low freezes all state
//   din         pixel bit
//   win         window including the current beat, tap r*K+c (tap 0 = oldest row/col)
//   win_valid   current beat completes a full window
//   win_last    current beat is the final pixel of the frame

module bnn_conv_mc_window_buf #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           clear,
    input  logic           en,
    input  logic           din,
    output logic [K*K-1:0] win,
    output logic           win_valid,
    output logic           win_last
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [COL_W-1:0]           col;
    logic [ROW_W-1:0]           row;
    logic [K-2:0][IMG_W-1:0]    lb;
    logic [K-1:0][K-1:0]        win_q;
    logic [K-1:0][K-1:0]        win_nxt;
    logic [K-1:0]               row_in;

    // Row K-1 is the live row; row K-2-j is fed by the oldest bit of line buffer j,
    // which is exactly one image row (j+1 rows total) behind the incoming pixel.
    always_comb begin
        row_in = '0;
        win_nxt = '0;
        row_in[K-1] = din;
        for (int r = 0; r < K - 1; r++) begin
            row_in[r] = lb[K-2-r][IMG_W-1];
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_nxt[r][c] = win_q[r][c+1];
            end
            win_nxt[r][K-1] = row_in[r];
        end
    end

    // The window is presented combinationally so the top can register results
    // one cycle after the completing beat.
    assign win       = win_nxt;
    assign win_valid = en && (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));
    assign win_last  = en && (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col   <= '0;
            row   <= '0;
            lb    <= '0;
            win_q <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            win_q <= win_nxt;
            lb[0] <= {lb[0][IMG_W-2:0], din};
            for (int j = 1; j < K - 1; j++) begin
                lb[j] <= {lb[j][IMG_W-2:0], lb[j-1][IMG_W-1]};
            end
            if (col == COL_W'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/bnn_conv_mc.sv
// rtl/bnn_conv_mc.sv - multi-channel XNOR-popcount KxK valid convolution engine
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   start             one-cycle frame start (honoured only in IDLE with weights loaded)
//   din, din_valid    raster pixel stream (1 = +1, 0 = -1) and its qualifier
//   weight_en, weight serial weight load, bit n -> channel n/(K*K), tap n%(K*K)
//   wload_done        all N_OCH*K*K weights present
//   busy              frame in progress
//   dout, ovalid      per-channel signed results, channel c at [c*OUT_W +: OUT_W]
//   done              pulse alongside the last result of a frame

module bnn_conv_mc
    import bnn_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int K     = 3,
    parameter int N_OCH = 4,
    parameter int OUT_W = result_w(K)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   din,
    input  logic                   din_valid,
    input  logic                   weight_en,
    input  logic                   weight,
    output logic                   wload_done,
    output logic                   busy,
    output logic [N_OCH*OUT_W-1:0] dout,
    output logic                   ovalid,
    output logic                   done
);

    localparam int KK = K * K;
    localparam int NW = N_OCH * KK;
    localparam int CW = $clog2(NW + 1);

    state_t             state_q;
    state_t             state_d;
    logic [NW-1:0]      wreg;
    logic [CW-1:0]      wcnt;
    logic               frame_clear;
    logic               accept;
    logic [KK-1:0]      win;
    logic               win_valid;
    logic               win_last;
    logic [N_OCH*OUT_W-1:0] res_d;

    assign frame_clear = (state_q == IDLE) && start && wload_done;
    // The done cycle still reads as RUN; beats offered then are not accepted.
    assign accept      = (state_q == RUN) && din_valid && !done;
    assign busy        = (state_q == RUN);

    bnn_conv_mc_window_buf #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K)
    ) u_window_buf (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (frame_clear),
        .en        (accept),
        .din       (din),
        .win       (win),
        .win_valid (win_valid),
        .win_last  (win_last)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && wload_done) state_d = RUN;
            RUN:     if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A weight_en after a completed load restarts the load at bit 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wreg       <= '0;
            wcnt       <= '0;
            wload_done <= 1'b0;
        end else if ((state_q == IDLE) && weight_en) begin
            if (wload_done) begin
                wreg[0]    <= weight;
                wcnt       <= CW'(1);
                wload_done <= 1'b0;
            end else begin
                wreg[wcnt] <= weight;
                wcnt       <= wcnt + CW'(1);
                wload_done <= (wcnt == CW'(NW - 1));
            end
        end
    end

    always_comb begin
        int p;
        int r;
        p = 0;
        r = 0;
        res_d = '0;
        for (int c = 0; c < N_OCH; c++) begin
            p = xnor_popcount(POP_MAX'(win), POP_MAX'(wreg[c*KK +: KK]), KK);
            r = 2 * p - KK;
            res_d[c*OUT_W +: OUT_W] = r[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout   <= '0;
            ovalid <= 1'b0;
            done   <= 1'b0;
        end else begin
            ovalid <= win_valid;
            done   <= win_valid && win_last;
            if (win_valid) begin
                dout <= res_d;
            end
        end
    end

endmodule

// File: doc/bnn_conv_mc.md
Name: bnn_conv_mc

Overview:
Parametrised multi-channel binary (XNOR-popcount) convolution engine. It accepts a raster-ordered 1-bit pixel stream and serially loaded 1-bit weights, and produces N_OCH signed K×K convolution results per window position ("valid" convolution, no padding). It is the successor to the single-channel fixed-3×3 conv/window pair. It adds configurable image size, kernel size and channel count, a per-pixel valid qualifier that allows stream gaps, and a weight-load completion flag.

Parameters:
IMG_W, 28, pixels per image row
IMG_H, 28, rows per frame
K, 3, kernel side (K×K window), 2..7
N_OCH, 4, output channels sharing one window
OUT_W, $clog2(K*K+1)+1, derived signed result width (5 for K=3)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame
din  in  1  pixel bit (1 = +1, 0 = -1)
din_valid  in  1  din qualifier
weight_en  in  1  weight bit valid
weight  in  1  serial weight bit (1 = +1, 0 = -1)
wload_done  out  1  all N_OCH*K*K weights loaded
busy  out  1  frame in progress
dout  out  N_OCH*OUT_W  channel c at bits [c*OUT_W +: OUT_W], signed
ovalid  out  1  dout valid
done  out  1  one-cycle frame-complete pulse

Behaviour:
- Reset is asynchronous, active-low. During and after reset: all outputs 0, FSM = IDLE, weight register 0, weight counter 0, line buffers 0, row/col counters 0.
- Weight load:
  - Accepted only in IDLE, one bit per weight_en cycle. Bit n goes to channel n/(K*K), tap n%(K*K).
  - Taps are in raster order: tap 0 = oldest row, oldest column.
  - When the counter reaches N_OCH*K*K, wload_done goes to 1 on the next cycle.
  - If weight_en is asserted while wload_done = 1, a new load starts: wload_done clears, the counter restarts at 1, and that bit is stored as bit 0.
  - Deasserting weight_en mid-load holds the counter; loading resumes on the next weight_en.
  - weight_en in RUN is ignored.
- FSM:
  - IDLE -> RUN on start && wload_done. start without wload_done is ignored.
  - RUN -> IDLE after the last window is emitted.
  - start, weight_en in RUN: ignored.
  - busy = (state == RUN).
- Entering RUN clears the row and column counters.
- In RUN, each din_valid beat shifts din into the K-row window, built from K-1 line buffers of IMG_W bits plus a K×K shift window. The column counter advances; at IMG_W-1 it wraps to 0 and the row counter advances.
- din_valid = 0 freezes all pipeline state, so gaps of any length are allowed. din_valid in IDLE is ignored.
- Window valid when row >= K-1 && col >= K-1 for the accepted beat. Each frame yields (IMG_W-K+1)*(IMG_H-K+1) results.
- Arithmetic, per channel: p = popcount(~(window ^ w_c)); result = 2*p - K*K, signed, range -K*K..+K*K. No saturation is needed at the derived OUT_W.
- Latency:
  - dout and ovalid are registered, 1 cycle after the accepted beat that completes a window.
  - ovalid is a single-cycle pulse per result.
  - dout holds its value between pulses.
- done pulses in the same cycle as the final ovalid. The FSM is in IDLE on the following cycle, so back-to-back start is legal then.
- Weights persist across frames until reloaded or reset.
- Reset mid-frame: immediate return to the reset state. Weights are lost and wload_done = 0.

Decomposition:
- Package bnn_pkg holds:
  - FSM state enum (IDLE, RUN)
  - function result_w(k) = $clog2(k*k+1)+1
  - XNOR-popcount function, shared with future FC layers
- Natural sub-module bnn_window_buf: line buffers, K×K window, row/col counters. Ports include din_valid and a frame-clear input; output is win_valid plus the flattened K*K window.
- The top level holds the weight shifter, FSM and N_OCH parallel popcount lanes.

Test Plan:
1. IMG_W=IMG_H=5, K=3, N_OCH=2. Load 18 ones; start; 25 pixels of 1 -> 9 ovalid pulses, both channels = +9, done on the 9th pulse, busy then 0.
2. Same geometry. ch0 weights all 1, ch1 all 0; pixels all 0 -> ch0 = -9, ch1 = +9 for all 9 outputs.
3. Checkerboard pixels (p = (r+c)&1), ch0 weights = checkerboard starting tap0 = 0 -> outputs alternate +9 / -9 in raster order, starting +9.
4. Run test 1 with din_valid random 50% duty -> identical results and count. ovalid never asserted without a preceding accepted beat.
5. start before wload_done, and weight_en during RUN -> start ignored (busy = 0); weights unchanged (outputs as test 1).
6. Assert rstn low after 12 pixels -> all outputs 0 immediately, wload_done = 0. Reload weights, run a full frame -> correct 9 results.
